// File: rtl/ndata_cyclic_checker.sv
// Sink-side scoreboard for a cyclic ndata stream: checks each accepted beat against a repeating expected list.
// Optional NDATA_CYCLIC_CHECKER_THROTTLE_EN adds LFSR-driven random back-pressure on ready.
module ndata_cyclic_checker #(
    parameter type data_t        = logic [7:0],
    parameter int  NUM_ELEMENTS  = 1,
    parameter int  NUM_DATABEATS = 1,
    parameter int  COUNT_W       = 32,
    localparam int IDX_W         = (NUM_DATABEATS > 1) ? $clog2(NUM_DATABEATS) : 1
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             clear,
    input  data_t [NUM_DATABEATS-1:0][NUM_ELEMENTS-1:0]      exp_data,
    input  logic  [NUM_DATABEATS-1:0][NUM_ELEMENTS-1:0]      exp_keep,
    input  logic  [7:0]                                      ready_threshold,
    input  data_t [NUM_ELEMENTS-1:0]                         in_data_data,
    input  logic  [NUM_ELEMENTS-1:0]                         in_data_keep,
    input  logic                                             in_data_last,
    input  logic                                             in_data_valid,
    output logic                                             in_data_ready,
    output logic  [COUNT_W-1:0]                              beat_count,
    output logic  [COUNT_W-1:0]                              packet_count,
    output logic  [COUNT_W-1:0]                              error_count,
    output logic                                             error,
    output logic  [IDX_W-1:0]                                first_err_beat,
    output logic  [2:0]                                      first_err_kind
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DATABEATS - 1);

    logic [IDX_W-1:0] r_idx;
    logic             w_accept;
    logic             w_dataMis;
    logic             w_keepMis;
    logic             w_lastMis;
    logic             w_mismatch;
    logic             w_readyNext;

    function automatic logic [COUNT_W-1:0] satInc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_accept = in_data_valid & in_data_ready;

    // Lanes whose expected keep is 0 are don't-care for the data comparison.
    always_comb begin
        w_dataMis = 1'b0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            if (exp_keep[r_idx][j] && (in_data_data[j] != exp_data[r_idx][j])) begin
                w_dataMis = 1'b1;
            end
        end
    end

    assign w_keepMis  = (in_data_keep != exp_keep[r_idx]);
    assign w_lastMis  = (in_data_last != (r_idx == LAST_IDX));
    assign w_mismatch = w_dataMis | w_keepMis | w_lastMis;

`ifdef NDATA_CYCLIC_CHECKER_THROTTLE_EN
    logic [15:0] r_lfsr;
    logic        w_lfsrFb;

    assign w_lfsrFb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_readyNext = (r_lfsr[7:0] < ready_threshold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else if (clear) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsrFb};
        end
    end
`else
    logic w_unused_threshold;

    assign w_unused_threshold = ^ready_threshold;
    assign w_readyNext        = 1'b1;
`endif

    // clear takes priority over a same-edge accept: that beat is dropped unchecked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_data_ready  <= 1'b0;
            r_idx          <= '0;
            beat_count     <= '0;
            packet_count   <= '0;
            error_count    <= '0;
            error          <= 1'b0;
            first_err_beat <= '0;
            first_err_kind <= '0;
        end else begin
            in_data_ready <= w_readyNext;
            if (clear) begin
                r_idx          <= '0;
                beat_count     <= '0;
                packet_count   <= '0;
                error_count    <= '0;
                error          <= 1'b0;
                first_err_beat <= '0;
                first_err_kind <= '0;
            end else if (w_accept) begin
                r_idx      <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                beat_count <= satInc(beat_count);
                if (in_data_last) begin
                    packet_count <= satInc(packet_count);
                end
                if (w_mismatch) begin
                    error_count <= satInc(error_count);
                    error       <= 1'b1;
                    if (!error) begin
                        first_err_beat <= r_idx;
                        first_err_kind <= {w_lastMis, w_keepMis, w_dataMis};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ndata_cyclic_checker.sv
// Randomized self-checking bench for ndata_cyclic_checker against a list-position reference model.
// Runs two instances (wide and 4-bit counters) on the same stream to cover saturation.
module tb_ndata_cyclic_checker;

    localparam int NB   = 3;
    localparam int NE   = 4;
    localparam int MAXW = 65535;
    localparam int MAXS = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic [NB-1:0][NE-1:0][7:0] expData;
    logic [NB-1:0][NE-1:0]      expKeep;
    logic [NE-1:0][7:0]         inData;
    logic [NE-1:0]              inKeep;
    logic                       inLast;
    logic                       inValid;

    logic        readyW, readyS;
    logic [15:0] beatW, packetW, errCntW;
    logic [3:0]  beatS, packetS, errCntS;
    logic        errorW, errorS;
    logic [1:0]  firstBeatW, firstBeatS;
    logic [2:0]  firstKindW, firstKindS;

    int checks = 0;
    int errors = 0;

    int mBeats, mPackets, mErrors, mSince, mFirstBeat, mFirstKind;
    bit mError, mReady;

    always #5 clk = ~clk;

    ndata_cyclic_checker #(
        .data_t(logic [7:0]), .NUM_ELEMENTS(NE), .NUM_DATABEATS(NB), .COUNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .exp_data(expData), .exp_keep(expKeep), .ready_threshold(8'd128),
        .in_data_data(inData), .in_data_keep(inKeep), .in_data_last(inLast),
        .in_data_valid(inValid), .in_data_ready(readyW),
        .beat_count(beatW), .packet_count(packetW), .error_count(errCntW),
        .error(errorW), .first_err_beat(firstBeatW), .first_err_kind(firstKindW)
    );

    ndata_cyclic_checker #(
        .data_t(logic [7:0]), .NUM_ELEMENTS(NE), .NUM_DATABEATS(NB), .COUNT_W(4)
    ) dutSat (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .exp_data(expData), .exp_keep(expKeep), .ready_threshold(8'd128),
        .in_data_data(inData), .in_data_keep(inKeep), .in_data_last(inLast),
        .in_data_valid(inValid), .in_data_ready(readyS),
        .beat_count(beatS), .packet_count(packetS), .error_count(errCntS),
        .error(errorS), .first_err_beat(firstBeatS), .first_err_kind(firstKindS)
    );

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int satTo(input int v, input int maxV);
        return (v > maxV) ? maxV : v;
    endfunction

    task automatic modelReset();
        mBeats = 0; mPackets = 0; mErrors = 0; mSince = 0;
        mFirstBeat = 0; mFirstKind = 0; mError = 0;
    endtask

    // The expected beat is simply the position in the list of the accepted-beat count since clear.
    task automatic modelStep();
        int  idx;
        bit  dm, km, lm;
        if (!rst_n) begin
            modelReset();
            mReady = 0;
        end else if (clear) begin
            modelReset();
            mReady = 1;
        end else begin
            if (inValid && mReady) begin
                idx = mSince % NB;
                dm = 0;
                for (int j = 0; j < NE; j++)
                    if (expKeep[idx][j] && inData[j] != expData[idx][j]) dm = 1;
                km = (inKeep != expKeep[idx]);
                lm = (inLast != (idx == NB - 1));
                mBeats++;
                if (inLast) mPackets++;
                if (dm || km || lm) begin
                    mErrors++;
                    if (!mError) begin
                        mFirstBeat = idx;
                        mFirstKind = {29'd0, lm, km, dm};
                    end
                    mError = 1;
                end
                mSince++;
            end
            mReady = 1;
        end
    endtask

    task automatic checkAll();
        checkOutput("readyW", readyW, mReady);
        checkOutput("beatW", beatW, satTo(mBeats, MAXW));
        checkOutput("packetW", packetW, satTo(mPackets, MAXW));
        checkOutput("errCntW", errCntW, satTo(mErrors, MAXW));
        checkOutput("errorW", errorW, mError);
        checkOutput("firstBeatW", firstBeatW, mFirstBeat);
        checkOutput("firstKindW", firstKindW, mFirstKind);
        checkOutput("readyS", readyS, mReady);
        checkOutput("beatS", beatS, satTo(mBeats, MAXS));
        checkOutput("packetS", packetS, satTo(mPackets, MAXS));
        checkOutput("errCntS", errCntS, satTo(mErrors, MAXS));
        checkOutput("errorS", errorS, mError);
    endtask

    task automatic applyStimulus(input logic v, input logic [NE-1:0][7:0] d,
                                 input logic [NE-1:0] k, input logic l, input logic clr);
        inValid = v; inData = d; inKeep = k; inLast = l; clear = clr;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    // Builds the correct beat for the model's next index, with garbage in don't-care lanes.
    task automatic makeBeat(output logic [NE-1:0][7:0] d, output logic [NE-1:0] k, output logic l);
        int idx;
        idx = mSince % NB;
        for (int j = 0; j < NE; j++)
            d[j] = expKeep[idx][j] ? expData[idx][j] : 8'($urandom);
        k = expKeep[idx];
        l = (idx == NB - 1);
    endtask

    task automatic idleCycle(input logic clr);
        logic [NE-1:0][7:0] d;
        d = {$urandom, $urandom};
        applyStimulus(1'b0, d, 4'($urandom), 1'($urandom), clr);
    endtask

    task automatic sendGood(input int n, input bit gaps);
        logic [NE-1:0][7:0] d;
        logic [NE-1:0]      k;
        logic               l;
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom % 4 == 0)) idleCycle(1'b0);
            makeBeat(d, k, l);
            applyStimulus(1'b1, d, k, l, 1'b0);
        end
    endtask

    initial begin
        logic [NE-1:0][7:0] d;
        logic [NE-1:0]      k;
        logic               l;
        bit                 badLast;

        rst_n = 1'b0; clear = 1'b0; inValid = 1'b0; inData = '0; inKeep = '0; inLast = 1'b0;
        for (int b = 0; b < NB; b++)
            for (int j = 0; j < NE; j++) expData[b][j] = 8'($urandom);
        expKeep[0] = 4'b1111;
        expKeep[1] = 4'b0011;
        expKeep[2] = 4'($urandom_range(1, 15));
        modelReset();
        mReady = 0;

        $display("[TB] reset state");
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        rst_n = 1'b1;
        idleCycle(1'b0);
        checkOutput("readyAfterReset", readyW, 1);

        $display("[TB] matched stream with don't-care garbage");
        sendGood(30, 1);
        checkOutput("matchedBeats", beatW, 30);
        checkOutput("matchedPackets", packetW, 10);
        checkOutput("matchedErrCnt", errCntW, 0);
        checkOutput("matchedError", errorW, 0);

        $display("[TB] corrupt lane 0 of beat 1");
        idleCycle(1'b1);
        sendGood(1, 0);
        makeBeat(d, k, l);
        d[0] = d[0] ^ 8'h5A;
        applyStimulus(1'b1, d, k, l, 1'b0);
        sendGood(1, 0);
        checkOutput("lane0Error", errorW, 1);
        checkOutput("lane0FirstBeat", firstBeatW, 1);
        checkOutput("lane0FirstKind", firstKindW, 3'b001);
        checkOutput("lane0ErrCnt", errCntW, 1);

        $display("[TB] last on beat 0 only");
        idleCycle(1'b1);
        for (int i = 0; i < 30; i++) begin
            makeBeat(d, k, l);
            applyStimulus(1'b1, d, k, (i % NB) == 0, 1'b0);
        end
        checkOutput("lastFirstBeat", firstBeatW, 0);
        checkOutput("lastFirstKind", firstKindW, 3'b100);
        checkOutput("lastErrCnt", errCntW, 20);

        $display("[TB] clear colliding with an accept");
        idleCycle(1'b1);
        sendGood(5, 0);
        makeBeat(d, k, l);
        applyStimulus(1'b1, d, k, l, 1'b1);
        checkOutput("clearBeats", beatW, 0);
        checkOutput("clearError", errorW, 0);
        sendGood(1, 0);
        checkOutput("afterClearBeats", beatW, 1);
        checkOutput("afterClearError", errorW, 0);

        $display("[TB] saturation of 4-bit counters");
        idleCycle(1'b1);
        sendGood(20, 0);
        checkOutput("satBeats", beatS, 15);
        checkOutput("satPackets", packetS, 6);
        checkOutput("wideBeats", beatW, 20);

        $display("[TB] randomized stream with corruptions, clears and a mid-stream reset");
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst_n = 1'b0;
                #2;
                modelReset();
                mReady = 0;
                checkAll();
                checkOutput("asyncReadyDrop", readyW, 0);
                idleCycle(1'b0);
                rst_n = 1'b1;
            end
            if ($urandom % 50 == 0) begin
                idleCycle(1'b1);
            end else if ($urandom % 5 == 0) begin
                idleCycle(1'b0);
            end else begin
                makeBeat(d, k, l);
                badLast = 0;
                case ($urandom % 8)
                    0: d[$urandom % NE] = 8'($urandom);
                    1: k = k ^ 4'(1 << ($urandom % NE));
                    2: badLast = 1;
                    default: ;
                endcase
                applyStimulus(1'b1, d, k, l ^ badLast, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
